// File: rtl/clk_sched_pkg.sv
// Shared definitions for the clock-enable scheduler.
// Contains the channel FSM encoding and the default base prescale.
package clk_sched_pkg;

    typedef logic [1:0] chan_state_t;

    localparam chan_state_t ST_OFF = 2'd0;
    localparam chan_state_t ST_ARM = 2'd1;
    localparam chan_state_t ST_RUN = 2'd2;

    // 1 us base tick at a 50 MHz system clock
    localparam int unsigned BASE_DIV_DEFAULT = 50;

endpackage

// File: rtl/clk_sched_chan.sv
// One clock-enable channel: OFF/ARM/RUN FSM, period counter, latched divide, strobe and toggle.
// Starts and stops are aligned to base ticks and period ends, so no runt periods occur.
module clk_sched_chan
    import clk_sched_pkg::*;
#(
    parameter int unsigned CNT_W = 26
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             tick,
    input  logic             req,
    input  logic [CNT_W-1:0] div,
    output logic             ce,
    output logic             toggle,
    output logic             active
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    chan_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] div_q, div_d;
    logic [CNT_W-1:0] div_eff;
    logic             ce_q, ce_d;
    logic             toggle_q, toggle_d;
    logic             active_q;
    logic             period_end;

    // A divide of zero behaves as one: strobe on every base tick
    assign div_eff    = (div == '0) ? CNT_ONE : div;
    assign period_end = tick && (cnt_q == div_q - CNT_ONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        div_d    = div_q;
        ce_d     = 1'b0;
        toggle_d = toggle_q;
        case (state_q)
            ST_OFF: begin
                if (req) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                if (!req) begin
                    state_d = ST_OFF;
                end else if (tick) begin
                    state_d = ST_RUN;
                    div_d   = div_eff;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                if (period_end) begin
                    ce_d     = 1'b1;
                    toggle_d = ~toggle_q;
                    cnt_d    = '0;
                    div_d    = div_eff;
                    // Stop only here; the final strobe above is still issued
                    if (!req) begin
                        state_d = ST_OFF;
                    end
                end else if (tick) begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_OFF;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q  <= ST_OFF;
            cnt_q    <= '0;
            div_q    <= CNT_ONE;
            ce_q     <= 1'b0;
            toggle_q <= 1'b0;
            active_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            div_q    <= div_d;
            ce_q     <= ce_d;
            toggle_q <= toggle_d;
            active_q <= (state_d == ST_RUN);
        end
    end

    assign ce     = ce_q;
    assign toggle = toggle_q;
    assign active = active_q;

endmodule

// File: rtl/clk_en_scheduler.sv
// Central clock-enable scheduler: shared base prescaler feeding NUM_CH independent channels.
// All strobes are single-cycle enables in the Clk domain; no derived clocks are produced.
module clk_en_scheduler
    import clk_sched_pkg::*;
#(
    parameter int unsigned NUM_CH   = 2,
    parameter int unsigned CNT_W    = 26,
    parameter int unsigned BASE_DIV = BASE_DIV_DEFAULT
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [NUM_CH-1:0]       ch_req,
    input  logic [NUM_CH*CNT_W-1:0] ch_div,
    output logic                    base_tick,
    output logic [NUM_CH-1:0]       ch_ce,
    output logic [NUM_CH-1:0]       ch_toggle,
    output logic [NUM_CH-1:0]       ch_active
);

    localparam int unsigned     BCNT_W   = $clog2(BASE_DIV);
    localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
    localparam logic [BCNT_W-1:0] BCNT_TOP = BCNT_W'(BASE_DIV - 1);

    logic [BCNT_W-1:0] bcnt_q, bcnt_d;
    logic              base_tick_q;
    logic              tick;

    // Internal tick leads base_tick by one cycle so channel strobes line up with it
    assign tick   = (bcnt_q == BCNT_TOP);
    assign bcnt_d = tick ? '0 : bcnt_q + BCNT_ONE;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bcnt_q      <= '0;
            base_tick_q <= 1'b0;
        end else begin
            bcnt_q      <= bcnt_d;
            base_tick_q <= tick;
        end
    end

    assign base_tick = base_tick_q;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        clk_sched_chan #(
            .CNT_W (CNT_W)
        ) u_chan (
            .Clk    (Clk),
            .Reset  (Reset),
            .tick   (tick),
            .req    (ch_req[i]),
            .div    (ch_div[i*CNT_W +: CNT_W]),
            .ce     (ch_ce[i]),
            .toggle (ch_toggle[i]),
            .active (ch_active[i])
        );
    end

endmodule

// File: tb/tb_clk_en_scheduler.sv
// Directed bench for clk_en_scheduler with BASE_DIV=4, CNT_W=8, NUM_CH=2 and a 20 ns clock.
// Expected strobe timings are hand-derived cycle offsets from tick-aligned start points.
module tb_clk_en_scheduler;

    localparam int unsigned NUM_CH   = 2;
    localparam int unsigned CNT_W    = 8;
    localparam int unsigned BASE_DIV = 4;

    logic                    Clk;
    logic                    Reset;
    logic [NUM_CH-1:0]       ch_req;
    logic [NUM_CH*CNT_W-1:0] ch_div;
    logic                    base_tick;
    logic [NUM_CH-1:0]       ch_ce;
    logic [NUM_CH-1:0]       ch_toggle;
    logic [NUM_CH-1:0]       ch_active;

    int cyc;
    int n_cmp;
    int n_bad;

    clk_en_scheduler #(
        .NUM_CH   (NUM_CH),
        .CNT_W    (CNT_W),
        .BASE_DIV (BASE_DIV)
    ) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .ch_req    (ch_req),
        .ch_div    (ch_div),
        .base_tick (base_tick),
        .ch_ce     (ch_ce),
        .ch_toggle (ch_toggle),
        .ch_active (ch_active)
    );

    initial Clk = 1'b0;
    always #10 Clk = ~Clk;

    // Clock edges since the last reset release
    always @(posedge Clk or posedge Reset) begin
        if (Reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic set_div(input int ch, input int val);
        ch_div[ch*CNT_W +: CNT_W] = CNT_W'(val);
    endtask

    task automatic align();
        while (cyc % 4 != 0) @(negedge Clk);
    endtask

    task automatic wait_ce(input int ch, input int bound, output int at);
        at = -1;
        for (int i = 0; i < bound && at < 0; i++) begin
            @(negedge Clk);
            if (ch_ce[ch] === 1'b1) at = cyc;
        end
    endtask

    task automatic test_reset();
        Reset  = 1'b1;
        ch_req = '0;
        ch_div = '0;
        repeat (5) @(negedge Clk);
        n_cmp++;
        if ({base_tick, ch_ce, ch_toggle, ch_active} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_hold: got %b expected 0", {base_tick, ch_ce, ch_toggle, ch_active});
        end
        repeat (5) @(negedge Clk);
        Reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge Clk);
            n_cmp++;
            if (base_tick !== (k % 4 == 0)) begin
                n_bad++;
                $display("FAIL base_tick cycle %0d: got %b expected %b", k, base_tick, (k % 4 == 0));
            end
        end
        n_cmp++;
        if ({ch_ce, ch_toggle, ch_active} !== 6'b0) begin
            n_bad++;
            $display("FAIL idle_outputs: got %b expected 0", {ch_ce, ch_toggle, ch_active});
        end
    endtask

    task automatic test_run();
        int c0, t1, t2;
        align();
        c0 = cyc;
        set_div(0, 3);
        ch_req[0] = 1'b1;
        repeat (3) @(negedge Clk);
        n_cmp++;
        if (ch_active[0] !== 1'b0) begin
            n_bad++; $display("FAIL run_arm_inactive: got %b expected 0", ch_active[0]);
        end
        @(negedge Clk);
        n_cmp++;
        if (ch_active[0] !== 1'b1) begin
            n_bad++; $display("FAIL run_active: got %b expected 1", ch_active[0]);
        end
        wait_ce(0, 20, t1);
        n_cmp++;
        if (t1 - c0 !== 16) begin
            n_bad++; $display("FAIL run_first_ce: got %0d expected 16", t1 - c0);
        end
        n_cmp++;
        if (ch_toggle[0] !== 1'b1) begin
            n_bad++; $display("FAIL run_toggle1: got %b expected 1", ch_toggle[0]);
        end
        @(negedge Clk);
        n_cmp++;
        if (ch_ce[0] !== 1'b0) begin
            n_bad++; $display("FAIL run_ce_width: got %b expected 0", ch_ce[0]);
        end
        wait_ce(0, 20, t2);
        n_cmp++;
        if (t2 - t1 !== 12) begin
            n_bad++; $display("FAIL run_spacing: got %0d expected 12", t2 - t1);
        end
        n_cmp++;
        if (ch_toggle[0] !== 1'b0) begin
            n_bad++; $display("FAIL run_toggle0: got %b expected 0", ch_toggle[0]);
        end
    endtask

    task automatic test_stop();
        int t0, t1, seen;
        t0 = cyc;
        repeat (5) @(negedge Clk);
        ch_req[0] = 1'b0;
        wait_ce(0, 20, t1);
        n_cmp++;
        if (t1 - t0 !== 12) begin
            n_bad++; $display("FAIL stop_final_ce: got %0d expected 12", t1 - t0);
        end
        n_cmp++;
        if ({ch_active[0], ch_toggle[0]} !== 2'b01) begin
            n_bad++;
            $display("FAIL stop_state: got active=%b toggle=%b expected active=0 toggle=1",
                     ch_active[0], ch_toggle[0]);
        end
        seen = 0;
        repeat (30) begin
            @(negedge Clk);
            if (ch_ce[0] !== 1'b0 || ch_active[0] !== 1'b0 || ch_toggle[0] !== 1'b1) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL stop_frozen: got %0d bad cycles expected 0", seen);
        end
    endtask

    task automatic test_div_change();
        int c0, ta, tb, tc, td;
        align();
        c0 = cyc;
        set_div(0, 3);
        ch_req[0] = 1'b1;
        wait_ce(0, 30, ta);
        n_cmp++;
        if (ta - c0 !== 16) begin
            n_bad++; $display("FAIL div_first_ce: got %0d expected 16", ta - c0);
        end
        repeat (3) @(negedge Clk);
        set_div(0, 5);
        wait_ce(0, 30, tb);
        n_cmp++;
        if (tb - ta !== 12) begin
            n_bad++; $display("FAIL div_current_period: got %0d expected 12", tb - ta);
        end
        wait_ce(0, 40, tc);
        n_cmp++;
        if (tc - tb !== 20) begin
            n_bad++; $display("FAIL div_next_period: got %0d expected 20", tc - tb);
        end
        n_cmp++;
        if (ch_toggle[0] !== 1'b0) begin
            n_bad++; $display("FAIL div_toggle: got %b expected 0", ch_toggle[0]);
        end
        repeat (2) @(negedge Clk);
        ch_req[0] = 1'b0;
        wait_ce(0, 40, td);
        n_cmp++;
        if (td - tc !== 20) begin
            n_bad++; $display("FAIL div_stop_ce: got %0d expected 20", td - tc);
        end
        n_cmp++;
        if ({ch_active[0], ch_toggle[0]} !== 2'b01) begin
            n_bad++;
            $display("FAIL div_stop_state: got active=%b toggle=%b expected active=0 toggle=1",
                     ch_active[0], ch_toggle[0]);
        end
    endtask

    task automatic test_arm_abort();
        int c0, t1, t2, t3, t4, seen;
        align();
        @(negedge Clk);
        set_div(1, 3);
        ch_req[1] = 1'b1;
        @(negedge Clk);
        ch_req[1] = 1'b0;
        seen = 0;
        repeat (16) begin
            @(negedge Clk);
            if (ch_ce[1] !== 1'b0 || ch_active[1] !== 1'b0) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL arm_abort: got %0d active/strobe cycles expected 0", seen);
        end
        align();
        c0 = cyc;
        set_div(1, 0);
        ch_req[1] = 1'b1;
        wait_ce(1, 20, t1);
        n_cmp++;
        if (t1 - c0 !== 8) begin
            n_bad++; $display("FAIL div0_first_ce: got %0d expected 8", t1 - c0);
        end
        n_cmp++;
        if (ch_toggle[1] !== 1'b1) begin
            n_bad++; $display("FAIL div0_toggle: got %b expected 1", ch_toggle[1]);
        end
        wait_ce(1, 8, t2);
        wait_ce(1, 8, t3);
        n_cmp++;
        if (t2 - t1 !== 4 || t3 - t2 !== 4) begin
            n_bad++;
            $display("FAIL div0_spacing: got %0d,%0d expected 4,4", t2 - t1, t3 - t2);
        end
        ch_req[1] = 1'b0;
        wait_ce(1, 8, t4);
        n_cmp++;
        if (t4 - t3 !== 4) begin
            n_bad++; $display("FAIL div0_stop_ce: got %0d expected 4", t4 - t3);
        end
        n_cmp++;
        if ({ch_active[1], ch_toggle[1]} !== 2'b00) begin
            n_bad++;
            $display("FAIL div0_stop_state: got active=%b toggle=%b expected 0,0",
                     ch_active[1], ch_toggle[1]);
        end
    endtask

    task automatic test_both_and_reset();
        int c0, t1, seen;
        align();
        c0 = cyc;
        set_div(0, 2);
        set_div(1, 2);
        ch_req = 2'b11;
        wait_ce(0, 30, t1);
        n_cmp++;
        if (t1 - c0 !== 12) begin
            n_bad++; $display("FAIL both_first_ce: got %0d expected 12", t1 - c0);
        end
        n_cmp++;
        if ({ch_ce, ch_toggle} !== 4'b1110) begin
            n_bad++; $display("FAIL both_coincident: got %b expected 1110", {ch_ce, ch_toggle});
        end
        seen = 0;
        repeat (7) begin
            @(negedge Clk);
            if (ch_ce !== 2'b00) seen++;
        end
        n_cmp++;
        if (seen !== 0) begin
            n_bad++; $display("FAIL both_gap: got %0d strobe cycles expected 0", seen);
        end
        @(negedge Clk);
        n_cmp++;
        if ({ch_ce, ch_toggle, ch_active} !== 6'b110111) begin
            n_bad++;
            $display("FAIL both_second: got %b expected 110111", {ch_ce, ch_toggle, ch_active});
        end
        Reset = 1'b1;
        #1;
        n_cmp++;
        if ({base_tick, ch_ce, ch_toggle, ch_active} !== 7'b0) begin
            n_bad++;
            $display("FAIL reset_mid_run: got %b expected 0", {base_tick, ch_ce, ch_toggle, ch_active});
        end
        ch_req = '0;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_run();
        test_stop();
        test_div_change();
        test_arm_abort();
        test_both_and_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
